sha256_multi: RTL and testbench

Parametrised multi-block SHA-256 compression engine and successor to the single-block `sha256` core. It accepts a stream of pre-padded 512-bit message blocks under a valid/ready handshake and chains the intermediate hash across blocks. It emits the 256-bit digest only after the block flagged last. Rounds per cycle are configurable, so the same block serves the area-lean and the throughput-oriented Hash160 builds.

---
 rtl/sha256_multi.sv | 160 ++++++++++++++++
 tb/tb_sha256_multi.sv | 206 ++++++++++++++++++++
 2 files changed

// File: rtl/sha256_multi.sv
// Multi-block SHA-256 compression engine: chains the intermediate hash across
// pre-padded 512-bit blocks, running ROUNDS_PER_CYCLE rounds per clock.
module sha256_multi #(
    parameter int ROUNDS_PER_CYCLE = 1
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic         in_first,
    input  logic         in_last,
    input  logic [511:0] M_in,
    output logic [255:0] H_out,
    output logic         out_valid,
    output logic         busy
);
    localparam int R = ROUNDS_PER_CYCLE;

    if (R != 1 && R != 2 && R != 4 && R != 8 && R != 16) begin : g_bad_rounds
        $error("sha256_multi: ROUNDS_PER_CYCLE must be 1, 2, 4, 8 or 16");
    end

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_RUN   = 2'd1;
    localparam logic [1:0] S_FINAL = 2'd2;

    localparam logic [0:7][31:0] IV = {
        32'h6a09e667, 32'hbb67ae85, 32'h3c6ef372, 32'ha54ff53a,
        32'h510e527f, 32'h9b05688c, 32'h1f83d9ab, 32'h5be0cd19
    };

    localparam logic [0:63][31:0] K = {
        32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5, 32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
        32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3, 32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
        32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc, 32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
        32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7, 32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
        32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13, 32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
        32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3, 32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
        32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5, 32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
        32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208, 32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2
    };

    function automatic logic [31:0] rotr(input logic [31:0] x, input int n);
        return (x >> n) | (x << (32 - n));
    endfunction

    function automatic logic [31:0] bsig0(input logic [31:0] x);
        return rotr(x, 2) ^ rotr(x, 13) ^ rotr(x, 22);
    endfunction

    function automatic logic [31:0] bsig1(input logic [31:0] x);
        return rotr(x, 6) ^ rotr(x, 11) ^ rotr(x, 25);
    endfunction

    function automatic logic [31:0] ssig0(input logic [31:0] x);
        return rotr(x, 7) ^ rotr(x, 18) ^ (x >> 3);
    endfunction

    function automatic logic [31:0] ssig1(input logic [31:0] x);
        return rotr(x, 17) ^ rotr(x, 19) ^ (x >> 10);
    endfunction

    logic [1:0]        r_state;
    logic [6:0]        r_round_cnt;
    logic [0:15][31:0] r_w;
    logic [0:7][31:0]  r_v;
    logic [0:7][31:0]  r_hc;
    logic              r_first;
    logic              r_last;
    logic [255:0]      r_h_out;
    logic              r_out_valid;

    logic [31:0]       w_ext [0:15+R];
    logic [0:15][31:0] w_w_next;
    logic [0:7][31:0]  w_v_next;
    logic [0:7][31:0]  w_hc_used;
    logic [0:7][31:0]  w_hc_new;
    logic [31:0]       w_t1;
    logic [31:0]       w_t2;
    logic [5:0]        w_kidx;

    // NOTE: blocking assignments here are deliberate: each unrolled round reads
    // the value the previous round just produced within the same cycle.
    always_comb begin
        w_t1     = '0;
        w_t2     = '0;
        w_kidx   = '0;
        w_v_next = r_v;
        for (int i = 0; i < 16; i++) w_ext[i] = r_w[i];
        for (int j = 0; j < R; j++)
            w_ext[16+j] = ssig1(w_ext[14+j]) + w_ext[9+j] + ssig0(w_ext[1+j]) + w_ext[j];
        for (int i = 0; i < 16; i++) w_w_next[i] = w_ext[R+i];
        for (int k = 0; k < R; k++) begin
            w_kidx   = r_round_cnt[5:0] + 6'(k);
            w_t1     = w_v_next[7] + bsig1(w_v_next[4])
                     + ((w_v_next[4] & w_v_next[5]) ^ (~w_v_next[4] & w_v_next[6]))
                     + K[w_kidx] + w_ext[k];
            w_t2     = bsig0(w_v_next[0])
                     + ((w_v_next[0] & w_v_next[1]) ^ (w_v_next[0] & w_v_next[2]) ^ (w_v_next[1] & w_v_next[2]));
            w_v_next = {w_t1 + w_t2, w_v_next[0], w_v_next[1], w_v_next[2],
                        w_v_next[3] + w_t1, w_v_next[4], w_v_next[5], w_v_next[6]};
        end
    end

    always_comb begin
        w_hc_used = r_first ? IV : r_hc;
        for (int i = 0; i < 8; i++) w_hc_new[i] = w_hc_used[i] + r_v[i];
    end

    // NOTE: the chain register resets to the IV rather than zero, so a first
    // block sent after reset without in_first still hashes from the IV.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= S_IDLE;
            r_round_cnt <= '0;
            r_w         <= '0;
            r_v         <= '0;
            r_hc        <= IV;
            r_first     <= 1'b0;
            r_last      <= 1'b0;
            r_h_out     <= '0;
            r_out_valid <= 1'b0;
        end else begin
            r_out_valid <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (in_valid) begin
                        r_w         <= M_in;
                        r_first     <= in_first;
                        r_last      <= in_last;
                        r_v         <= in_first ? IV : r_hc;
                        r_round_cnt <= '0;
                        r_state     <= S_RUN;
                    end
                end
                S_RUN: begin
                    r_v         <= w_v_next;
                    r_w         <= w_w_next;
                    r_round_cnt <= r_round_cnt + 7'(R);
                    if (r_round_cnt == 7'(64 - R)) r_state <= S_FINAL;
                end
                S_FINAL: begin
                    r_hc <= w_hc_new;
                    if (r_last) begin
                        r_h_out     <= w_hc_new;
                        r_out_valid <= 1'b1;
                    end
                    r_state <= S_IDLE;
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign in_ready  = (r_state == S_IDLE);
    assign busy      = (r_state != S_IDLE);
    assign out_valid = r_out_valid;
    assign H_out     = r_h_out;

endmodule

// File: tb/tb_sha256_multi.sv
// Scoreboard bench for sha256_multi: one engine per legal ROUNDS_PER_CYCLE,
// each driven by its own directed sequence and checked by its own monitor.
module tb_sha256_multi;

    typedef struct {
        logic [255:0] d;
        int           due;
    } exp_t;

    localparam logic [511:0] M_ABC   = {32'h61626380, 448'h0, 32'h00000018};
    localparam logic [511:0] M_EMPTY = {32'h80000000, 480'h0};
    localparam logic [511:0] M_B1    = {
        32'h61626364, 32'h62636465, 32'h63646566, 32'h64656667,
        32'h65666768, 32'h66676869, 32'h6768696a, 32'h68696a6b,
        32'h696a6b6c, 32'h6a6b6c6d, 32'h6b6c6d6e, 32'h6c6d6e6f,
        32'h6d6e6f70, 32'h6e6f7071, 32'h80000000, 32'h00000000
    };
    localparam logic [511:0] M_B2    = {480'h0, 32'h000001c0};

    localparam logic [255:0] D_ABC   = 256'hba7816bf8f01cfea414140de5dae2223b00361a396177a9cb410ff61f20015ad;
    localparam logic [255:0] D_2B    = 256'h248d6a61d20638b8e5c026930c3e6039a33ce45964ff2167f6ecedd419db06c1;
    localparam logic [255:0] D_EMPTY = 256'he3b0c44298fc1c149afbf4c8996fb92427ae41e4649b934ca495991b7852b855;

    logic       clk = 1'b0;
    int         cyc = 0;
    int         n_checks = 0;
    int         n_errors = 0;
    logic [4:0] done_vec;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [255:0] act, input logic [255:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    for (genvar gi = 0; gi < 5; gi++) begin : g_inst
        localparam int R = 1 << gi;
        localparam int P = 64 / R + 2;

        logic         rst = 1'b1;
        logic         in_valid = 1'b0;
        logic         in_ready;
        logic         in_first = 1'b0;
        logic         in_last = 1'b0;
        logic [511:0] M_in = '0;
        logic [255:0] H_out;
        logic         out_valid;
        logic         busy;
        logic         r_done = 1'b0;
        exp_t         sb[$];

        sha256_multi #(.ROUNDS_PER_CYCLE(R)) u_dut (
            .clk       (clk),
            .rst       (rst),
            .in_valid  (in_valid),
            .in_ready  (in_ready),
            .in_first  (in_first),
            .in_last   (in_last),
            .M_in      (M_in),
            .H_out     (H_out),
            .out_valid (out_valid),
            .busy      (busy)
        );

        assign done_vec[gi] = r_done;

        task automatic chk(input string n, input logic [255:0] a, input logic [255:0] e);
            check($sformatf("R%0d %s", R, n), a, e);
        endtask

        // Digest becomes visible in the interval after accept edge + P-1.
        task automatic send(input logic [511:0] m, input logic f, input logic l,
                            input logic [255:0] exp_d, output int acc, output logic ov_seen);
            int budget;
            acc     = -1;
            ov_seen = 1'b0;
            budget  = 0;
            @(negedge clk);
            M_in     = m;
            in_first = f;
            in_last  = l;
            in_valid = 1'b1;
            while (!in_ready && budget < 400) begin
                @(negedge clk);
                budget++;
            end
            if (!in_ready) begin
                chk("accept timeout", 256'(in_ready), 256'd1);
                in_valid = 1'b0;
            end else begin
                ov_seen = out_valid;
                @(posedge clk);
                #1;
                acc      = cyc;
                in_valid = 1'b0;
                if (l) sb.push_back('{d: exp_d, due: acc + P - 1});
            end
        endtask

        task automatic wait_drain();
            int n;
            n = 0;
            while (sb.size() != 0 && n < 400) begin
                @(negedge clk);
                n++;
            end
            chk("scoreboard drained", 256'(sb.size()), 256'd0);
        endtask

        initial begin
            exp_t e;
            forever begin
                @(negedge clk);
                if (!rst && out_valid) begin
                    if (sb.size() == 0) begin
                        chk("unexpected out_valid", 256'(out_valid), 256'd0);
                    end else begin
                        e = sb.pop_front();
                        chk("digest", H_out, e.d);
                        chk("out_valid cycle", 256'(cyc), 256'(e.due));
                    end
                end
            end
        end

        initial begin
            int   a0;
            int   a1;
            int   bad;
            logic ov;

            repeat (3) @(negedge clk);
            chk("reset H_out", H_out, 256'd0);
            chk("reset out_valid", 256'(out_valid), 256'd0);
            chk("reset busy", 256'(busy), 256'd0);
            rst = 1'b0;
            @(negedge clk);
            chk("in_ready after reset", 256'(in_ready), 256'd1);

            send(M_ABC, 1'b1, 1'b1, D_ABC, a0, ov);
            wait_drain();

            send(M_B1, 1'b1, 1'b0, '0, a0, ov);
            send(M_B2, 1'b0, 1'b1, D_2B, a1, ov);
            chk("back-to-back period", 256'(a1 - a0), 256'(P));
            wait_drain();

            send(M_B1, 1'b1, 1'b0, '0, a0, ov);
            send(M_B2, 1'b0, 1'b1, D_2B, a1, ov);
            send(M_EMPTY, 1'b1, 1'b1, D_EMPTY, a1, ov);
            wait_drain();

            // Second block is presented while the first is still running.
            send(M_ABC, 1'b1, 1'b1, D_ABC, a0, ov);
            @(negedge clk);
            chk("stall in_ready", 256'(in_ready), 256'd0);
            chk("stall busy", 256'(busy), 256'd1);
            send(M_EMPTY, 1'b1, 1'b1, D_EMPTY, a1, ov);
            chk("accept in out_valid cycle", 256'(ov), 256'd1);
            chk("stall accept cycle", 256'(a1 - a0), 256'(P));
            wait_drain();

            send(M_B1, 1'b1, 1'b0, '0, a0, ov);
            repeat ((R == 1) ? 20 : 32 / R) @(negedge clk);
            chk("busy before reset", 256'(busy), 256'd1);
            rst = 1'b1;
            #1;
            chk("mid reset H_out", H_out, 256'd0);
            chk("mid reset out_valid", 256'(out_valid), 256'd0);
            chk("mid reset busy", 256'(busy), 256'd0);
            repeat (2) @(negedge clk);
            rst = 1'b0;
            @(negedge clk);
            chk("in_ready after mid reset", 256'(in_ready), 256'd1);
            send(M_ABC, 1'b0, 1'b1, D_ABC, a0, ov);
            wait_drain();

            bad = 0;
            repeat (100) begin
                @(negedge clk);
                if (H_out !== D_ABC || out_valid !== 1'b0 || busy !== 1'b0) bad++;
            end
            chk("idle hold violations", 256'(bad), 256'd0);
            chk("idle hold H_out", H_out, D_ABC);

            r_done = 1'b1;
        end
    end

    initial begin
        fork
            wait (done_vec == 5'h1f);
            repeat (20000) @(posedge clk);
        join_any
        disable fork;
        check("all sequences completed", 256'(done_vec), 256'(5'h1f));
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
